txreq_arb: RTL and testbench
============================

Name: txreq_arb

Overview:
- Scheduler for the HN-F TXREQ link channel.
- Arbitrates round-robin among NUM_REQ internal request sources, for example SLC ReadNoSnp issue and future POCQ retry or writeback sources.
- Tracks CHI link-layer credits returned on TXREQLCRDV. Issues at most one flit per cycle, and only while a credit is held.
- Drives TXREQFLIT/TXREQFLITV/TXREQFLITPEND directly. It replaces the single-source slc_txreq to hnf_txreq path.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- FLIT_W, $bits(reqflit_t), request flit width.
- MAX_LCRD, 15, maximum link credits held (CHI limit). The counter is 4 bits.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_flit  in  NUM_REQ*FLIT_W  flattened flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- txreq_en  in  1  1 = grants allowed; 0 = stop issuing (flush or link deactivate).
- TXREQFLIT  out  FLIT_W  registered outgoing flit.
- TXREQFLITV  out  1  registered flit valid.
- TXREQFLITPEND  out  1  early flit indication.
- TXREQLCRDV  in  1  link credit return, one credit per cycle high.
- lcrd_cnt  out  4  current credit count (debug).
- lcrd_ovf  out  1  sticky error: credit returned while count == MAX_LCRD.

Behaviour:

Reset (asynchronous, takes effect immediately, including mid-transfer):
- TXREQFLITV=0, TXREQFLIT=0, lcrd_cnt=0, lcrd_ovf=0, rr_ptr=NUM_REQ-1.
- req_ready and TXREQFLITPEND are forced 0 while reset is high.
- A flit in flight when reset asserts is dropped. The requester is not re-granted for it.

Grant (combinational in cycle N):
- can_issue = txreq_en && (lcrd_cnt != 0).
- If can_issue and any req_valid: winner = first requester with valid, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
- req_ready[winner]=1; all other bits 0.
- Handshake completes when req_valid[i] && req_ready[i]. The requester must hold valid and flit stable until ready.
- If can_issue=0, req_ready=0.

Issue (registered, edge ending cycle N):
- On a grant: TXREQFLIT <= req_flit[winner], TXREQFLITV <= 1, rr_ptr <= winner.
- With no grant: TXREQFLITV <= 0, TXREQFLIT holds, rr_ptr holds.
- Latency from grant to TXREQFLITV is exactly 1 cycle. Throughput is 1 flit/cycle while credits last.

TXREQFLITPEND:
- TXREQFLITPEND = txreq_en && (lcrd_cnt != 0) && |req_valid.
- High in cycle N whenever TXREQFLITV can be high in cycle N+1. Never low in the cycle before a TXREQFLITV pulse.

Credit counter:
- Grant only: cnt-1.
- TXREQLCRDV only: cnt+1.
- Both in the same cycle: cnt unchanged.
- TXREQLCRDV when cnt == MAX_LCRD with no grant: cnt saturates at MAX_LCRD and lcrd_ovf <= 1. lcrd_ovf stays set until reset.
- No grant is possible at cnt == 0, so the counter never underflows.
- A credit returned in cycle N is usable for a grant in cycle N+1.

Fairness:
- A requester holding valid is granted within NUM_REQ grants.
- A single active requester is granted every credit-available cycle.

txreq_en deassert:
- Takes effect the same cycle: no grant, no PEND.
- A flit already registered still drives TXREQFLITV in the following cycle.
- Credits keep accumulating while txreq_en is low.

Test Plan:
- Reset, then 3 TXREQLCRDV pulses, then req_valid=2'b01 held: lcrd_cnt goes 1, 2, 3; three consecutive grants to req0; TXREQFLITV high for 3 cycles starting 1 cycle after the first grant; lcrd_cnt back to 0; PEND low afterwards.
- NUM_REQ=2, 4 credits, both valid continuously: grants alternate 0, 1, 0, 1 starting with req0; TXREQFLIT values match the respective flits; then stall at cnt=0 with req_ready=0.
- cnt=1, grant and TXREQLCRDV in the same cycle: cnt stays 1 and the next cycle grants again; flits are back-to-back with no bubble.
- Return 16 credits with no requests: lcrd_cnt saturates at 15 and lcrd_ovf=1 from the 16th pulse, remaining set.
- 5 credits, req valid, txreq_en dropped for 3 cycles: req_ready=0 and PEND=0 during that window; cnt unchanged; issuing resumes the cycle txreq_en returns.
- Assert reset in the cycle TXREQFLITV=1 with cnt=7: TXREQFLITV drops immediately; cnt=0; rr_ptr restored so req0 wins first after reset.

Source files
------------

// File: rtl/txreq_arb.sv
// Round-robin scheduler for the HN-F TXREQ link channel.
// It grants one requester per cycle while a CHI link credit is held, and it registers the granted flit onto TXREQFLIT.
module txreq_arb #(
  parameter int NUM_REQ  = 2,
  parameter int FLIT_W   = 64,
  parameter int MAX_LCRD = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic                      txreq_en,
  output logic [FLIT_W-1:0]         TXREQFLIT,
  output logic                      TXREQFLITV,
  output logic                      TXREQFLITPEND,
  input  logic                      TXREQLCRDV,
  output logic [3:0]                lcrd_cnt,
  output logic                      lcrd_ovf
);

  localparam int               PTR_W   = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] RR_INIT = PTR_W'(NUM_REQ - 1);
  localparam logic [3:0]       MAX_C   = 4'(MAX_LCRD);

  logic [FLIT_W-1:0] flit_arr [NUM_REQ];
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              flitv_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  winner;
  logic              grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign flit_arr[gi] = req_flit[gi*FLIT_W +: FLIT_W];
  end

  // Reset gates the grant so ready/PEND are low for the whole reset window.
  assign grant = !reset && txreq_en && (cnt_q != 4'd0) && (|req_valid);

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;
    winner = rr_ptr_q;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant && (winner == PTR_W'(gi));
  end

  always_comb begin
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    flit_d   = flit_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      flit_d   = flit_arr[winner];
      rr_ptr_d = winner;
    end
    // A credit returned in the same cycle as a grant cancels out.
    if (grant && !TXREQLCRDV) begin
      cnt_d = cnt_q - 4'd1;
    end else if (TXREQLCRDV && !grant) begin
      if (cnt_q == MAX_C) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flit_q   <= '0;
      flitv_q  <= 1'b0;
      cnt_q    <= 4'd0;
      ovf_q    <= 1'b0;
      rr_ptr_q <= RR_INIT;
    end else begin
      flit_q   <= flit_d;
      flitv_q  <= grant;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign TXREQFLIT     = flit_q;
  assign TXREQFLITV    = flitv_q;
  assign TXREQFLITPEND = grant;
  assign lcrd_cnt      = cnt_q;
  assign lcrd_ovf      = ovf_q;

endmodule

// File: tb/tb_txreq_arb.sv
// Scoreboard bench for txreq_arb: a credit/round-robin reference model predicts the grants and pushes the expected flits.
// A monitor pops and compares the expected flits whenever TXREQFLITV is high.
module tb_txreq_arb;
  localparam int N    = 3;
  localparam int FW   = 16;
  localparam int MAXC = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    vld = '0;
  logic [N-1:0]    req_ready;
  logic [FW-1:0]   flit [N];
  logic [N*FW-1:0] req_flit;
  logic            en = 1'b0;
  logic            lcrdv = 1'b0;
  logic [FW-1:0]   txflit;
  logic            txv, txpend, ovf;
  logic [3:0]      cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt, m_last, last_w;
  bit m_ovf, m_v;
  logic [FW-1:0] exp_q[$];
  int grant_log[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_flit[gi*FW +: FW] = flit[gi];
  end

  txreq_arb #(.NUM_REQ(N), .FLIT_W(FW), .MAX_LCRD(MAXC)) dut (
    .clock(clk), .reset(rst), .req_valid(vld), .req_ready(req_ready),
    .req_flit(req_flit), .txreq_en(en), .TXREQFLIT(txflit), .TXREQFLITV(txv),
    .TXREQFLITPEND(txpend), .TXREQLCRDV(lcrdv), .lcrd_cnt(cnt), .lcrd_ovf(ovf)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(string name, int num, int e0, int e1, int e2, int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, 32'(grant_log.size()), 32'(num));
    for (int i = 0; i < num && i < grant_log.size(); i++)
      chk({name, "_winner"}, 32'(grant_log[i]), 32'(e[i]));
    grant_log.delete();
  endtask

  // Check one cycle against the model, then let the clock edge advance the model state.
  task automatic step();
    int w;
    bit g;
    w = -1;
    @(negedge clk);
    g = en && (m_cnt != 0) && (vld != '0);
    if (g) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (vld[idx] && w < 0) w = idx;
      end
    end
    chk("ready", 32'(req_ready), g ? (32'd1 << w) : 32'd0);
    chk("pend", 32'(txpend), 32'(g));
    chk("lcrd_cnt", 32'(cnt), 32'(m_cnt));
    chk("lcrd_ovf", 32'(ovf), 32'(m_ovf));
    chk("flitv", 32'(txv), 32'(m_v));
    if (g) begin
      exp_q.push_back(flit[w]);
      grant_log.push_back(w);
    end
    @(posedge clk);
    #1;
    m_v = g;
    if (g && !lcrdv) m_cnt--;
    else if (lcrdv && !g) begin
      if (m_cnt == MAXC) m_ovf = 1'b1;
      else m_cnt++;
    end
    if (g) begin
      m_last  = w;
      flit[w] = FW'($urandom);
    end
    last_w = g ? w : -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_cnt = 0; m_last = N - 1; m_ovf = 1'b0; m_v = 1'b0;
    exp_q.delete();
    grant_log.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_credits(int n);
    vld = '0; lcrdv = 1'b1;
    repeat (n) step();
    lcrdv = 1'b0;
  endtask

  // Monitor: every issued flit must match the oldest predicted flit.
  initial begin
    logic [FW-1:0] e;
    forever begin
      @(negedge clk);
      if (txv === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL flit_unexpected: got %0h expected none at %0t", txflit, $time);
        end else begin
          e = exp_q.pop_front();
          chk("flit", 32'(txflit), 32'(e));
          $display("[TB] flit %0h issued (expected %0h)", txflit, e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) flit[i] = FW'($urandom);
    m_cnt = 0; m_last = N - 1; m_ovf = 1'b0; m_v = 1'b0; last_w = -1;
    vld = '1; en = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_flitv", 32'(txv), 32'd0);
    chk("rst_flit", 32'(txflit), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_pend", 32'(txpend), 32'd0);
    @(posedge clk); #1; rst = 1'b0; vld = '0;

    // Three credits, then a single requester drains them back to back.
    load_credits(3);
    vld = 3'b001;
    repeat (5) step();
    chk_log("t1", 3, 0, 0, 0, 0);

    // Two requesters with four credits must alternate, starting from req0.
    do_reset();
    load_credits(4);
    vld = 3'b011;
    repeat (6) step();
    chk_log("t2", 4, 0, 1, 0, 1);

    // At cnt=1, a grant and a credit return in the same cycle keep the count.
    load_credits(1);
    vld = 3'b001; lcrdv = 1'b1;
    step();
    lcrdv = 1'b0;
    repeat (2) step();
    chk_log("t3", 2, 0, 0, 0, 0);

    // Credits saturate at MAX and the overflow flag is sticky.
    load_credits(16);
    repeat (2) step();
    chk("t4_cnt_sat", 32'(cnt), 32'(MAXC));
    chk("t4_ovf", 32'(ovf), 32'd1);

    // Disabling txreq_en blocks grants and PEND but not credit counting.
    do_reset();
    load_credits(5);
    vld = 3'b001; en = 1'b0;
    repeat (3) step();
    chk_log("t5_off", 0, 0, 0, 0, 0);
    en = 1'b1;
    repeat (6) step();
    chk("t5_grants", 32'(grant_log.size()), 32'd5);
    grant_log.delete();

    // Reset during a live flit drops it and restores the round-robin pointer.
    vld = '0;
    load_credits(8);
    vld = 3'b010;
    step();
    vld = '0;
    @(negedge clk);
    chk("t6_v_before", 32'(txv), 32'd1);
    chk("t6_cnt_before", 32'(cnt), 32'd7);
    #2 rst = 1'b1; vld = '1;
    #1;
    chk("t6_v_dropped", 32'(txv), 32'd0);
    chk("t6_cnt_cleared", 32'(cnt), 32'd0);
    chk("t6_ready_rst", 32'(req_ready), 32'd0);
    chk("t6_pend_rst", 32'(txpend), 32'd0);
    m_cnt = 0; m_last = N - 1; m_ovf = 1'b0; m_v = 1'b0;
    exp_q.delete();
    grant_log.delete();
    @(posedge clk); #1; rst = 1'b0;
    load_credits(1);
    vld = '1;
    repeat (2) step();
    chk_log("t6_first", 1, 0, 0, 0, 0);

    // Randomised traffic that respects the hold-until-ready rule.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      lcrdv = ($urandom_range(0, 99) < 40);
      en    = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (!vld[i] || last_w == i) begin
          if (!vld[i]) flit[i] = FW'($urandom);
          vld[i] = $urandom_range(0, 1) == 1;
        end
      end
      step();
    end
    grant_log.delete();

    vld = '0; lcrdv = 1'b0; en = 1'b1;
    repeat (3) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
